// File: rtl/sparse_pkg.sv
// Shared types and default sizing for the sparse encoder and its Sparse_MUX users.
// Optional zero-element statistics are enabled by defining SPARSE_ENCODER_STATS_EN.
package sparse_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_BLOCK_LEN  = 8;

  typedef enum logic [1:0] {
    COLLECT   = 2'd0,
    EMIT_MASK = 2'd1,
    EMIT_VAL  = 2'd2
  } state_t;

endpackage

// File: rtl/sparse_next_index.sv
// Combinational lowest-set-bit finder used to walk the pending mask during value emission.
module sparse_next_index #(
  parameter int N = 8
) (
  input  logic [N-1:0]         pending,
  output logic [$clog2(N)-1:0] idx,
  output logic                 found
);

  localparam int IW = $clog2(N);

  // Scanning high-to-low lets the last hit (the lowest index) win.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pending[i]) begin
        idx   = IW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sparse_encoder.sv
// Dense-to-sparse block encoder: one mask beat per block followed by its nonzero values.
// Define SPARSE_ENCODER_STATS_EN to build the saturating zero_count statistic.
//
// Handshake: a beat moves on a port only in a cycle where its valid and ready are both 1;
// while out_valid is 1 and out_ready is 0 every out_* field is held unchanged.
module sparse_encoder
  import sparse_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BLOCK_LEN  = DEF_BLOCK_LEN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_is_mask,
  output logic [BLOCK_LEN-1:0]  out_mask,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [15:0]           zero_count,
  output state_t                fsm_state
);

  localparam int             IW       = $clog2(BLOCK_LEN);
  localparam logic [IW-1:0]  LAST_IDX = IW'(BLOCK_LEN - 1);

  state_t                 state, state_nxt;
  logic [IW-1:0]          cnt;
  logic [BLOCK_LEN-1:0]   mask_q;
  logic [BLOCK_LEN-1:0]   pend_q;
  logic [DATA_WIDTH-1:0]  mem [BLOCK_LEN];
  logic [IW-1:0]          idx;
  logic                   found;
  logic [BLOCK_LEN-1:0]   idx_onehot;
  logic                   accept;
  logic                   out_fire;
  logic                   nz;

  sparse_next_index #(.N(BLOCK_LEN)) u_next_index (
    .pending (pend_q),
    .idx     (idx),
    .found   (found)
  );

  assign idx_onehot = BLOCK_LEN'(1) << idx;
  assign accept     = in_valid && in_ready;
  assign out_fire   = out_valid && out_ready;
  assign nz         = (in_data != '0);
  assign fsm_state  = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= COLLECT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_is_mask = 1'b0;
    out_last    = 1'b0;
    out_mask    = '0;
    out_data    = '0;
    case (state)
      COLLECT: begin
        in_ready = rst_n;
        if (in_valid && rst_n && cnt == LAST_IDX) state_nxt = EMIT_MASK;
      end
      EMIT_MASK: begin
        out_valid   = 1'b1;
        out_is_mask = 1'b1;
        out_mask    = mask_q;
        out_last    = (mask_q == '0);
        if (out_ready) state_nxt = (mask_q == '0) ? COLLECT : EMIT_VAL;
      end
      EMIT_VAL: begin
        out_valid = found;
        out_data  = mem[idx];
        // Last value beat is the one whose bit is the only one still pending.
        out_last  = ((pend_q & ~idx_onehot) == '0);
        if (out_ready && out_last) state_nxt = COLLECT;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      mask_q <= '0;
      pend_q <= '0;
    end else begin
      if (accept) begin
        cnt    <= (cnt == LAST_IDX) ? '0 : cnt + 1'b1;
        mask_q <= ((cnt == '0) ? '0 : mask_q) | (BLOCK_LEN'(nz) << cnt);
      end
      if (out_fire && state == EMIT_MASK) pend_q <= mask_q;
      if (out_fire && state == EMIT_VAL)  pend_q <= pend_q & ~idx_onehot;
    end
  end

  // Element storage needs no reset: it is only read in EMIT_VAL after a full block.
  always_ff @(posedge clk) begin
    if (accept) mem[cnt] <= in_data;
  end

`ifdef SPARSE_ENCODER_STATS_EN
  logic [15:0] zc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   zc_q <= '0;
    else if (accept && !nz && zc_q != 16'hFFFF)   zc_q <= zc_q + 16'd1;
  end

  assign zero_count = zc_q;
`else
  assign zero_count = '0;
`endif

endmodule

// File: tb/tb_sparse_encoder.sv
// Self-checking bench for sparse_encoder: block-level reference model plus directed literal checks.
// Zero-count expectations follow SPARSE_ENCODER_STATS_EN when the bench is built with it.
module tb_sparse_encoder;
  import sparse_pkg::*;

  localparam int DW = 8;
  localparam int BL = 8;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_is_mask;
  logic [BL-1:0] out_mask;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [15:0]   zero_count;
  state_t        fsm_state;

  always #5 clk = ~clk;

  sparse_encoder #(.DATA_WIDTH(DW), .BLOCK_LEN(BL)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_is_mask (out_is_mask),
    .out_mask    (out_mask),
    .out_data    (out_data),
    .out_last    (out_last),
    .zero_count  (zero_count),
    .fsm_state   (fsm_state)
  );

  // Beat record: {is_mask, last, mask, data}; unused field forced to 0.
  localparam int BW = 2 + BL + DW;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] blk[$];
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] obs_q[$];
  int            zc_m = 0;
  int            acc_cnt = 0;
  logic          prev_stall = 1'b0;
  logic [BW-1:0] prev_snap = '0;
  int            rdy_mode = 0;  // 0: always ready, 1: toggle, 2: random, 3: hold low

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] beat(input logic m, input logic l,
                                         input logic [BL-1:0] mk, input logic [DW-1:0] d);
    return {m, l, mk, d};
  endfunction

  // Expected beats of a complete block, straight from the encoding rules.
  task automatic model_block();
    logic [BL-1:0] m;
    int            hi;
    m  = '0;
    hi = -1;
    for (int i = 0; i < BL; i++) if (blk[i] != 0) begin m[i] = 1'b1; hi = i; end
    exp_q.push_back(beat(1'b1, m == '0, m, '0));
    for (int i = 0; i < BL; i++)
      if (blk[i] != 0) exp_q.push_back(beat(1'b0, i == hi, '0, blk[i]));
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    logic [BW-1:0] cur;
    logic [BW-1:0] e;
    if (!rst_n) begin
      blk.delete();
      exp_q.delete();
      zc_m       = 0;
      prev_stall = 1'b0;
    end else begin
      cur = beat(out_is_mask, out_last, out_is_mask ? out_mask : '0, out_is_mask ? '0 : out_data);
      check("in_ready", in_ready, exp_q.size() == 0);
      check("out_valid", out_valid, exp_q.size() != 0);
      check("zero_count", zero_count, zc_m);
      if (prev_stall) check("stall_stable", cur, prev_snap);
      if (out_valid && out_ready && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("beat", cur, e);
        obs_q.push_back(cur);
      end
      prev_stall = out_valid && !out_ready;
      prev_snap  = cur;
      if (in_valid && in_ready) begin
        blk.push_back(in_data);
        acc_cnt++;
`ifdef SPARSE_ENCODER_STATS_EN
        if (in_data == 0 && zc_m < 65535) zc_m++;
`endif
        if (blk.size() == BL) begin
          model_block();
          blk.delete();
        end
      end
    end
  end

  // ---------------- out_ready driver ----------------
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = ~out_ready;
      2: out_ready = ($urandom_range(0, 2) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  // ---------------- driver tasks ----------------
  task automatic send_elem(input logic [DW-1:0] v);
    int t = 0;
    in_valid = 1'b1;
    in_data  = v;
    while (!in_ready && t < 200) begin @(posedge clk); #1; t++; end
    if (t >= 200) begin n_checks++; n_fail++; $display("FAIL send_timeout: in_ready stuck 0 expected 1"); end
    @(posedge clk); #1;
  endtask

  task automatic send_block(input logic [DW-1:0] v [BL]);
    for (int i = 0; i < BL; i++) send_elem(v[i]);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 500) begin @(posedge clk); #1; t++; end
    if (t >= 500) begin n_checks++; n_fail++; $display("FAIL drain_timeout: %0d beats left expected 0", exp_q.size()); end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0;
    #2;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_bits", {out_is_mask, out_last, out_mask, out_data}, 0);
    check("rst_zero_count", zero_count, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);
  endtask

  // ---------------- test sequence ----------------
  logic [DW-1:0] v [BL];
  int            start_acc;

  initial begin
    @(posedge clk); #1;
    do_reset();

    // Mixed block with a negative value.
    obs_q.delete();
    v = '{8'd0, 8'd5, 8'd0, 8'd0, 8'd7, 8'd0, 8'd0, 8'hFF};
    send_block(v);
    drain();
    check("mixed_beats", obs_q.size(), 4);
    if (obs_q.size() == 4) begin
      check("mixed_mask", obs_q[0], beat(1'b1, 1'b0, 8'b1001_0010, 8'h00));
      check("mixed_v0", obs_q[1], beat(1'b0, 1'b0, 8'h00, 8'd5));
      check("mixed_v1", obs_q[2], beat(1'b0, 1'b0, 8'h00, 8'd7));
      check("mixed_v2", obs_q[3], beat(1'b0, 1'b1, 8'h00, 8'hFF));
    end

    // All-zero block: mask beat only.
    obs_q.delete();
    v = '{default: 8'd0};
    send_block(v);
    drain();
    check("zero_beats", obs_q.size(), 1);
    if (obs_q.size() == 1) check("zero_mask", obs_q[0], beat(1'b1, 1'b1, 8'h00, 8'h00));
`ifdef SPARSE_ENCODER_STATS_EN
    check("zero_cnt_lit", zero_count, 16'd13);
`else
    check("zero_cnt_lit", zero_count, 16'd0);
`endif

    // Dense block under a toggling out_ready.
    obs_q.delete();
    rdy_mode = 1;
    v = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    send_block(v);
    drain();
    rdy_mode = 0;
    check("dense_beats", obs_q.size(), 9);
    if (obs_q.size() == 9) begin
      check("dense_mask", obs_q[0], beat(1'b1, 1'b0, 8'hFF, 8'h00));
      check("dense_v0", obs_q[1], beat(1'b0, 1'b0, 8'h00, 8'd1));
      check("dense_v7", obs_q[8], beat(1'b0, 1'b1, 8'h00, 8'd8));
    end

    // Reset after three accepted elements discards the partial block.
    send_elem(8'd9); send_elem(8'd0); send_elem(8'd4);
    do_reset();
    obs_q.delete();
    v = '{8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd9};
    send_block(v);
    drain();
    check("fresh_beats", obs_q.size(), 3);
    if (obs_q.size() == 3) check("fresh_mask", obs_q[0], beat(1'b1, 1'b0, 8'h81, 8'h00));

    // Reset while a mask beat is stalled.
    rdy_mode = 3;
    send_block(v);
    repeat (3) @(posedge clk);
    #1;
    check("stalled_valid", out_valid, 1);
    do_reset();
    rdy_mode = 0;

    // Continuous in_valid over four blocks.
    start_acc = acc_cnt;
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < BL; i++)
        send_elem(($urandom_range(0, 1) == 0) ? 8'd0 : DW'($urandom_range(1, 255)));
    in_valid = 1'b0;
    drain();
    check("cont_accepted", acc_cnt - start_acc, 32);

    // Random traffic with random back-pressure and input gaps.
    rdy_mode = 2;
    for (int c = 0; c < 1500; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = ($urandom_range(0, 1) == 0) ? 8'd0 : DW'($urandom_range(0, 255));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rdy_mode = 0;
    drain();
    check("random_model_empty", exp_q.size(), 0);

`ifdef SPARSE_ENCODER_STATS_EN
    // Saturation of the zero counter.
    do_reset();
    start_acc = acc_cnt;
    in_valid  = 1'b1;
    in_data   = 8'd0;
    for (int c = 0; c < 90000 && (acc_cnt - start_acc) < 70000; c++) begin
      @(posedge clk); #1;
      if (!in_ready) begin end
    end
    in_valid = 1'b0;
    drain();
    check("zc_saturated", zero_count, 16'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sparse_encoder.md
SPARSE_ENCODER -- requirements
Module: sparse_encoder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of one element (INT8).
REQ-002 SHALL have parameter BLOCK_LEN, default 8: elements per block; power of two, 2..32.
REQ-003 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1: dense element offered.
REQ-006 SHALL have port in_ready, output, 1: encoder accepts element.
REQ-007 SHALL have port in_data, input, DATA_WIDTH: dense element.
REQ-008 SHALL have port out_valid, output, 1: output beat offered.
REQ-009 SHALL have port out_ready, input, 1: downstream accepts beat.
REQ-010 SHALL have port out_is_mask, output, 1: 1 = mask beat, 0 = value beat.
REQ-011 SHALL have port out_mask, output, BLOCK_LEN: sparse_index bitmap; bit i = 1 iff element i nonzero; valid on mask beat.
REQ-012 SHALL have port out_data, output, DATA_WIDTH: nonzero value; valid on value beat.
REQ-013 SHALL have port out_last, output, 1: final beat of block.
REQ-014 SHALL have port zero_count, output, 16: zero elements dropped (see Configuration).

Function
REQ-015 SHALL transfer on a port only in cycles where valid and ready are both 1.
REQ-016 SHALL implement FSM states COLLECT, EMIT_MASK, EMIT_VAL.
REQ-017 COLLECT: in_ready = 1; each accepted element stored at position cnt, mask bit cnt = (in_data != 0), cnt increments.
REQ-018 SHALL go COLLECT -> EMIT_MASK on acceptance of element BLOCK_LEN-1; cnt wraps to 0.
REQ-019 SHALL hold in_ready = 0 outside COLLECT.
REQ-020 EMIT_MASK: out_valid = 1, out_is_mask = 1, out_last = 1 iff mask all zero; the first mask beat appears the cycle after the last element is accepted.
REQ-021 On mask-beat transfer SHALL go to EMIT_VAL if mask nonzero, else to COLLECT.
REQ-022 EMIT_VAL: SHALL emit stored nonzero elements in ascending index order, one per transfer, out_is_mask = 0.
REQ-023 SHALL assert out_last on the value beat of the highest set mask bit, then return to COLLECT.
REQ-024 SHALL hold out_mask, out_data, out_is_mask and out_last stable while out_valid = 1 and out_ready = 0.
REQ-025 SHALL emit a fully dense block as 1 mask beat + BLOCK_LEN value beats, and an all-zero block as mask beat only.
REQ-026 Zero test SHALL be an exact compare of all DATA_WIDTH bits; values pass unmodified.

Reset
REQ-027 rst_n low SHALL immediately force state COLLECT, cnt 0, stored mask 0, in_ready 0, out_valid 0, out_is_mask 0, out_last 0, out_mask 0, out_data 0, zero_count 0.
REQ-028 SHALL raise in_ready the first cycle after rst_n deasserts; any partial or undelivered block is discarded on reset.

Configuration
REQ-029 Macro SPARSE_ENCODER_STATS_EN defined: zero_count SHALL increment by 1 per accepted zero element, saturating at 16'hFFFF.
REQ-030 Macro undefined: zero_count SHALL be driven constant 0 and no counter logic SHALL exist.

Structure
REQ-031 Package sparse_pkg SHALL hold the FSM state enum and default DATA_WIDTH/BLOCK_LEN constants, shared with Sparse_MUX users.
REQ-032 Sub-module sparse_next_index SHALL return the lowest set bit index of a pending mask plus a found flag; it is combinational and used by EMIT_VAL.

Verification
REQ-033 Block 0,5,0,0,7,0,0,-1 (BLOCK_LEN 8), out_ready 1 -> mask 8'b10010010, then 5, 7, 8'hFF; out_last on 8'hFF.
REQ-034 All-zero block -> single beat, out_is_mask 1, out_mask 0, out_last 1; zero_count += 8 with macro, stays 0 without.
REQ-035 Dense block 1..8 with out_ready toggling 1/0 every cycle -> 9 beats, each held stable while stalled, values 1..8 in order.
REQ-036 rst_n pulsed low after 3 elements accepted -> all outputs 0 immediately; next 8 elements form a fresh block with correct mask.
REQ-037 in_valid held 1 continuously, out_ready 1 -> in_ready low from mask cycle until last beat transfers, no element lost or duplicated over 4 blocks.
REQ-038 With macro, 70000 zero elements -> zero_count saturates at 16'hFFFF.
